soc_system_ocram_arbiter: RTL and testbench
===========================================

// Module: soc_system_ocram_arbiter
// PURPOSE
//  Shares one single-port 16K x 32 on-chip RAM (1-cycle read latency) between two Avalon-MM masters.
//  Round-robin or fixed-priority grant; at most one command accepted per cycle, so full throughput is kept.
//  Returns readdata with readdatavalid to the master that issued the read.
//  Optional zero-fill engine clears the RAM after reset or on request.
// PARAMETERS
//  ADDR_W          14     word address width; RAM depth = 2**ADDR_W
//  DATA_W          32     data width
//  BE_W            4      byteenable width (DATA_W/8)
//  PRIORITY_MODE   0      0 = round-robin; 1 = m0 fixed priority over m1
//  CLEAR_ON_RESET  0      1 = zero-fill whole RAM after reset before serving masters
// PORTS
//  clk               in   1       single clock for all logic
//  reset_n           in   1       synchronous, active-low reset
//  mN_address        in   ADDR_W  master N word address (N = 0,1)
//  mN_byteenable     in   BE_W    master N byte lanes
//  mN_read           in   1       master N read request
//  mN_write          in   1       master N write request
//  mN_writedata      in   DATA_W  master N write data
//  mN_waitrequest    out  1       high = master N command not accepted this cycle
//  mN_readdata       out  DATA_W  = ram_readdata (shared fan-out)
//  mN_readdatavalid  out  1       master N read data valid this cycle
//  clear_req         in   1       pulse: start runtime zero-fill
//  init_done         out  1       high when FSM is in RUN
//  err_rw            out  1       sticky: some master asserted read & write in the same cycle
//  ram_address       out  ADDR_W  to RAM
//  ram_byteenable    out  BE_W    to RAM
//  ram_chipselect    out  1       to RAM
//  ram_write         out  1       to RAM
//  ram_writedata     out  DATA_W  to RAM
//  ram_readdata      in   DATA_W  from RAM; valid the cycle after a read is presented
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge):
//   - FSM=INIT; last_grant=1 (m0 wins first tie); rd_pending=0; clr_addr=0; err_rw=0.
//   - While reset_n=0: both waitrequest=1, readdatavalid=0, ram_chipselect=0, ram_write=0, init_done=0.
//  FSM states:
//   - INIT: 1 cycle, both waitrequest=1 -> CLEAR if CLEAR_ON_RESET, else RUN.
//   - CLEAR: each cycle writes 0 to clr_addr with all byteenables set; clr_addr++.
//     Both waitrequest=1. Exits to RUN in the cycle after clr_addr=2**ADDR_W-1 is written
//     (2**ADDR_W write cycles); clr_addr returns to 0.
//   - RUN: arbitration; init_done=1. clear_req=1 -> CLEAR next cycle. clear_req is ignored
//     outside RUN.
//  Arbitration (RUN, combinational, same cycle):
//   - reqN = mN_read | mN_write.
//   - A master is granted only if it requests and clear_req=0. Only one requester -> it wins.
//   - Both request: mode 0 grants ~last_grant; mode 1 grants m0.
//   - Granted master: waitrequest=0, its command is driven to the RAM with ram_chipselect=1.
//   - Any other master: waitrequest=1 (mN_waitrequest=1 also when idle).
//   - last_grant updates only on a grant.
//   - No request or clear_req=1: ram_chipselect=0, ram_write=0.
//  Read/write:
//   - Write: ram_write=1 and is complete on acceptance.
//   - Read: rd_pending<=1 and rd_owner<=N at the edge. In the next cycle
//     mN_readdatavalid=rd_pending & (rd_owner==N). Fixed latency of 1, in order.
//   - Back-to-back reads from alternating masters are allowed every cycle.
//  Read & write asserted together by one master: write performed, read dropped (no valid), err_rw<=1.
//  A read accepted in the last RUN cycle still returns readdatavalid in the first CLEAR cycle.
//  Write then read of the same address in consecutive cycles returns the new data.
// TESTING
//  1. Reset, CLEAR_ON_RESET=0: init_done=1 from cycle 2. m0 writes 0xDEADBEEF @0x0010, then reads it
//     -> m0_readdatavalid=1 one cycle after accept with 0xDEADBEEF, m1_readdatavalid stays 0.
//  2. Both masters read continuously, mode 0 -> grants m0,m1,m0,m1..., one valid per cycle to the
//     alternating owner. Mode 1 -> m1 waitrequest=1 for the whole burst.
//  3. m1 writes 0x0000FF00 with byteenable=4'b0010 over 0x11223344 @0x3FFF, then reads -> 0x1122FF44.
//  4. CLEAR_ON_RESET=1, ADDR_W=4 -> 16 zero writes, init_done rises cycle 18; any address reads 0.
//  5. clear_req together with m0 read -> m0 waitrequest=1, CLEAR entered. A read accepted in the
//     prior cycle still returns valid.
//  6. m0 asserts read & write together -> write performed, no readdatavalid, err_rw=1 until reset.
//     Drop reset_n with a read pending -> no readdatavalid after reset.

Source files
------------

// File: rtl/soc_system_ocram_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM with 1-cycle read latency.
// Also owns a zero-fill engine that clears the RAM after reset (optional) or on clear_req.
module soc_system_ocram_arbiter #(
    parameter int ADDR_W         = 14,
    parameter int DATA_W         = 32,
    parameter int BE_W           = 4,
    parameter int PRIORITY_MODE  = 0,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    input  logic              clear_req,
    output logic              init_done,
    output logic              err_rw,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    input  logic [DATA_W-1:0] ram_readdata
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t            state;
    logic              last_grant;
    logic              rd_pending;
    logic              rd_owner;
    logic              err_q;
    logic [ADDR_W-1:0] clr_addr;

    logic req0, req1, serve, clearing, gnt0, gnt1;

    // Handshake: a command is accepted in any cycle where mN_read|mN_write is high and
    // mN_waitrequest is low; read data follows exactly one cycle later with readdatavalid.
    assign req0     = m0_read | m0_write;
    assign req1     = m1_read | m1_write;
    assign serve    = reset_n && (state == ST_RUN) && !clear_req;
    assign clearing = reset_n && (state == ST_CLEAR);
    // On a tie, m0 wins under fixed priority, or when m1 was the last master granted.
    assign gnt0     = serve && req0 && (!req1 || (PRIORITY_MODE != 0) || last_grant);
    assign gnt1     = serve && req1 && !gnt0;

    always_comb begin
        ram_address    = m0_address;
        ram_byteenable = m0_byteenable;
        ram_writedata  = m0_writedata;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        if (clearing) begin
            ram_address    = clr_addr;
            ram_byteenable = '1;
            ram_writedata  = '0;
            ram_chipselect = 1'b1;
            ram_write      = 1'b1;
        end else if (gnt1) begin
            ram_address    = m1_address;
            ram_byteenable = m1_byteenable;
            ram_writedata  = m1_writedata;
            ram_chipselect = 1'b1;
            ram_write      = m1_write;
        end else if (gnt0) begin
            ram_chipselect = 1'b1;
            ram_write      = m0_write;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_INIT;
            last_grant <= 1'b1;
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
            clr_addr   <= '0;
            err_q      <= 1'b0;
        end else begin
            // A read paired with a write in the same command is dropped.
            rd_pending <= (gnt0 && m0_read && !m0_write) || (gnt1 && m1_read && !m1_write);
            if (gnt0 || gnt1) begin
                last_grant <= gnt1;
                rd_owner   <= gnt1;
            end
            if ((m0_read && m0_write) || (m1_read && m1_write))
                err_q <= 1'b1;
            case (state)
                ST_INIT:  state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
                ST_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == {ADDR_W{1'b1}})
                        state <= ST_RUN;
                end
                ST_RUN:   if (clear_req) state <= ST_CLEAR;
                default:  state <= ST_INIT;
            endcase
        end
    end

    assign m0_waitrequest   = !gnt0;
    assign m1_waitrequest   = !gnt1;
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m0_readdatavalid = reset_n && rd_pending && !rd_owner;
    assign m1_readdatavalid = reset_n && rd_pending && rd_owner;
    assign init_done        = reset_n && (state == ST_RUN);
    assign err_rw           = err_q;

endmodule

// File: tb/tb_soc_system_ocram_arbiter.sv
// Directed bench: instance a (round-robin, full depth, no clear on reset) and
// instance b (fixed priority, 16 words, clear on reset) share clock, reset and master inputs.
module tb_soc_system_ocram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [13:0] m0_address = '0, m1_address = '0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic        clear_req = 1'b0;

    logic        a_m0_waitrequest, a_m0_readdatavalid, a_m1_waitrequest, a_m1_readdatavalid;
    logic [31:0] a_m0_readdata, a_m1_readdata, a_ram_writedata, a_ram_readdata;
    logic        a_init_done, a_err_rw, a_ram_chipselect, a_ram_write;
    logic [13:0] a_ram_address;
    logic [3:0]  a_ram_byteenable;

    logic        b_m0_waitrequest, b_m0_readdatavalid, b_m1_waitrequest, b_m1_readdatavalid;
    logic [31:0] b_m0_readdata, b_m1_readdata, b_ram_writedata, b_ram_readdata;
    logic        b_init_done, b_err_rw, b_ram_chipselect, b_ram_write;
    logic [3:0]  b_ram_address;
    logic [3:0]  b_ram_byteenable;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    soc_system_ocram_arbiter #(.ADDR_W(14), .PRIORITY_MODE(0), .CLEAR_ON_RESET(0)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(a_m0_waitrequest),
        .m0_readdata(a_m0_readdata), .m0_readdatavalid(a_m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(a_m1_waitrequest),
        .m1_readdata(a_m1_readdata), .m1_readdatavalid(a_m1_readdatavalid),
        .clear_req(clear_req), .init_done(a_init_done), .err_rw(a_err_rw),
        .ram_address(a_ram_address), .ram_byteenable(a_ram_byteenable),
        .ram_chipselect(a_ram_chipselect), .ram_write(a_ram_write),
        .ram_writedata(a_ram_writedata), .ram_readdata(a_ram_readdata)
    );

    soc_system_ocram_arbiter #(.ADDR_W(4), .PRIORITY_MODE(1), .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address[3:0]), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(b_m0_waitrequest),
        .m0_readdata(b_m0_readdata), .m0_readdatavalid(b_m0_readdatavalid),
        .m1_address(m1_address[3:0]), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(b_m1_waitrequest),
        .m1_readdata(b_m1_readdata), .m1_readdatavalid(b_m1_readdatavalid),
        .clear_req(1'b0), .init_done(b_init_done), .err_rw(b_err_rw),
        .ram_address(b_ram_address), .ram_byteenable(b_ram_byteenable),
        .ram_chipselect(b_ram_chipselect), .ram_write(b_ram_write),
        .ram_writedata(b_ram_writedata), .ram_readdata(b_ram_readdata)
    );

    // Single-port RAM models with byte enables and 1-cycle read latency.
    logic [31:0] mem_a [0:16383];
    logic [31:0] mem_b [0:15];

    initial begin
        for (int i = 0; i < 16; i++) mem_b[i] = 32'hA5A5_A5A5;
    end

    always @(posedge clk) begin
        if (a_ram_chipselect && a_ram_write) begin
            for (int i = 0; i < 4; i++)
                if (a_ram_byteenable[i]) mem_a[a_ram_address][8*i +: 8] <= a_ram_writedata[8*i +: 8];
        end else if (a_ram_chipselect) begin
            a_ram_readdata <= mem_a[a_ram_address];
        end
        if (b_ram_chipselect && b_ram_write) begin
            for (int i = 0; i < 4; i++)
                if (b_ram_byteenable[i]) mem_b[b_ram_address][8*i +: 8] <= b_ram_writedata[8*i +: 8];
        end else if (b_ram_chipselect) begin
            b_ram_readdata <= mem_b[b_ram_address];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF; clear_req = 1'b0;
    endtask

    // Leaves the bench in cycle 1 after reset release (FSM in INIT).
    task automatic do_reset();
        tick();
        reset_n = 1'b0;
        idle();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        m0_read = 1'b1;
        m1_write = 1'b1;
        tick();
        tick();
        sample();
        tests_run++;
        if (a_m0_waitrequest !== 1'b1 || a_m1_waitrequest !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_waitrequest: got %b%b expected 11", a_m0_waitrequest, a_m1_waitrequest);
        end
        tests_run++;
        if (a_ram_chipselect !== 1'b0 || a_ram_write !== 1'b0 || a_init_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ram_ctl: cs=%b write=%b init_done=%b expected 0 0 0",
                     a_ram_chipselect, a_ram_write, a_init_done);
        end
        tests_run++;
        if (a_m0_readdatavalid !== 1'b0 || a_m1_readdatavalid !== 1'b0 || a_err_rw !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid_err: rdv=%b%b err_rw=%b expected 00 0",
                     a_m0_readdatavalid, a_m1_readdatavalid, a_err_rw);
        end
        tick();
        reset_n = 1'b1;
        idle();
        m0_read = 1'b1;
        sample();
        tests_run++;
        if (a_init_done !== 1'b0 || a_m0_waitrequest !== 1'b1 || a_ram_chipselect !== 1'b0) begin
            tests_failed++;
            $display("FAIL init_cycle1: init_done=%b m0_wait=%b cs=%b expected 0 1 0",
                     a_init_done, a_m0_waitrequest, a_ram_chipselect);
        end
        tick();
        idle();
        sample();
        tests_run++;
        if (a_init_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL init_cycle2: init_done=%b expected 1", a_init_done);
        end
    endtask

    task automatic test_write_read();
        tick();
        m0_write = 1'b1; m0_address = 14'h0010; m0_writedata = 32'hDEAD_BEEF; m0_byteenable = 4'hF;
        sample();
        tests_run++;
        if (a_m0_waitrequest !== 1'b0 || a_ram_chipselect !== 1'b1 || a_ram_write !== 1'b1 ||
            a_ram_address !== 14'h0010 || a_ram_writedata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL m0_write: wait=%b cs=%b wr=%b addr=%h data=%h expected 0 1 1 0010 deadbeef",
                     a_m0_waitrequest, a_ram_chipselect, a_ram_write, a_ram_address, a_ram_writedata);
        end
        tick();
        m0_write = 1'b0; m0_read = 1'b1;
        sample();
        tests_run++;
        if (a_m0_waitrequest !== 1'b0 || a_ram_write !== 1'b0 || a_m0_readdatavalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL m0_read_accept: wait=%b wr=%b rdv=%b expected 0 0 0",
                     a_m0_waitrequest, a_ram_write, a_m0_readdatavalid);
        end
        tick();
        idle();
        sample();
        tests_run++;
        if (a_m0_readdatavalid !== 1'b1 || a_m0_readdata !== 32'hDEAD_BEEF || a_m1_readdatavalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL m0_read_data: rdv0=%b data=%h rdv1=%b expected 1 deadbeef 0",
                     a_m0_readdatavalid, a_m0_readdata, a_m1_readdatavalid);
        end
        tick();
        sample();
        tests_run++;
        if (a_m0_readdatavalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL m0_read_single: rdv=%b expected 0", a_m0_readdatavalid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        tick();
        m0_read = 1'b1; m0_address = 14'h0010;
        m1_read = 1'b1; m1_address = 14'h0020;
        for (int i = 0; i < 6; i++) begin
            sample();
            tests_run++;
            if (a_m0_waitrequest !== (i % 2 == 1) || a_m1_waitrequest !== (i % 2 == 0)) begin
                tests_failed++;
                $display("FAIL rr_grant[%0d]: wait=%b%b expected %b%b", i, a_m0_waitrequest,
                         a_m1_waitrequest, (i % 2 == 1), (i % 2 == 0));
            end
            if (i > 0) begin
                tests_run++;
                if (a_m0_readdatavalid !== ((i - 1) % 2 == 0) || a_m1_readdatavalid !== ((i - 1) % 2 == 1)) begin
                    tests_failed++;
                    $display("FAIL rr_valid[%0d]: rdv=%b%b expected %b%b", i, a_m0_readdatavalid,
                             a_m1_readdatavalid, ((i - 1) % 2 == 0), ((i - 1) % 2 == 1));
                end
                if ((i - 1) % 2 == 0) begin
                    tests_run++;
                    if (a_m0_readdata !== 32'hDEAD_BEEF) begin
                        tests_failed++;
                        $display("FAIL rr_data[%0d]: got %h expected deadbeef", i, a_m0_readdata);
                    end
                end
            end
            tick();
        end
        idle();
        sample();
        tests_run++;
        if (a_m0_readdatavalid !== 1'b0 || a_m1_readdatavalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rr_last_valid: rdv=%b%b expected 01", a_m0_readdatavalid, a_m1_readdatavalid);
        end
    endtask

    task automatic test_byte_write();
        tick();
        m1_write = 1'b1; m1_address = 14'h3FFF; m1_writedata = 32'h1122_3344; m1_byteenable = 4'hF;
        sample();
        tests_run++;
        if (a_m1_waitrequest !== 1'b0 || a_m0_waitrequest !== 1'b1) begin
            tests_failed++;
            $display("FAIL m1_write_grant: wait=%b%b expected 10", a_m0_waitrequest, a_m1_waitrequest);
        end
        tick();
        m1_writedata = 32'h0000_FF00; m1_byteenable = 4'b0010;
        sample();
        tests_run++;
        if (a_ram_byteenable !== 4'b0010 || a_ram_address !== 14'h3FFF) begin
            tests_failed++;
            $display("FAIL m1_byte_cmd: be=%b addr=%h expected 0010 3fff", a_ram_byteenable, a_ram_address);
        end
        tick();
        m1_write = 1'b0; m1_read = 1'b1;
        sample();
        tick();
        idle();
        sample();
        tests_run++;
        if (a_m1_readdatavalid !== 1'b1 || a_m1_readdata !== 32'h1122_FF44 || a_m0_readdatavalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL m1_byte_read: rdv1=%b data=%h rdv0=%b expected 1 1122ff44 0",
                     a_m1_readdatavalid, a_m1_readdata, a_m0_readdatavalid);
        end
    endtask

    task automatic test_rw_conflict();
        tick();
        m0_read = 1'b1; m0_write = 1'b1; m0_address = 14'h0020; m0_writedata = 32'hCAFE_F00D;
        sample();
        tests_run++;
        if (a_m0_waitrequest !== 1'b0 || a_ram_write !== 1'b1) begin
            tests_failed++;
            $display("FAIL rw_accept: wait=%b wr=%b expected 0 1", a_m0_waitrequest, a_ram_write);
        end
        tick();
        idle();
        sample();
        tests_run++;
        if (a_m0_readdatavalid !== 1'b0 || a_err_rw !== 1'b1) begin
            tests_failed++;
            $display("FAIL rw_drop: rdv=%b err_rw=%b expected 0 1", a_m0_readdatavalid, a_err_rw);
        end
        tick();
        m0_read = 1'b1;
        sample();
        tick();
        idle();
        sample();
        tests_run++;
        if (a_m0_readdatavalid !== 1'b1 || a_m0_readdata !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL rw_written: rdv=%b data=%h expected 1 cafef00d", a_m0_readdatavalid, a_m0_readdata);
        end
        tick();
        tick();
        sample();
        tests_run++;
        if (a_err_rw !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_sticky: err_rw=%b expected 1", a_err_rw);
        end
        tick();
        m0_read = 1'b1;
        sample();
        tick();
        reset_n = 1'b0;
        idle();
        sample();
        tests_run++;
        if (a_m0_readdatavalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_pending_rdv: rdv=%b expected 0", a_m0_readdatavalid);
        end
        tick();
        reset_n = 1'b1;
        sample();
        tests_run++;
        if (a_m0_readdatavalid !== 1'b0 || a_err_rw !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_reset: rdv=%b err_rw=%b expected 0 0", a_m0_readdatavalid, a_err_rw);
        end
    endtask

    task automatic test_clear_req();
        int k;
        tick();
        tick();
        m0_read = 1'b1; m0_address = 14'h0010;
        sample();
        tests_run++;
        if (a_m0_waitrequest !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_prior_read: wait=%b expected 0", a_m0_waitrequest);
        end
        tick();
        clear_req = 1'b1;
        sample();
        tests_run++;
        if (a_m0_waitrequest !== 1'b1 || a_ram_chipselect !== 1'b0 || a_init_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL clr_req_block: wait=%b cs=%b init_done=%b expected 1 0 1",
                     a_m0_waitrequest, a_ram_chipselect, a_init_done);
        end
        tests_run++;
        if (a_m0_readdatavalid !== 1'b1 || a_m0_readdata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL clr_prior_valid: rdv=%b data=%h expected 1 deadbeef", a_m0_readdatavalid, a_m0_readdata);
        end
        tick();
        clear_req = 1'b0;
        sample();
        tests_run++;
        if (a_init_done !== 1'b0 || a_m0_waitrequest !== 1'b1 || a_ram_write !== 1'b1 ||
            a_ram_address !== 14'h0000 || a_ram_writedata !== 32'h0 || a_m0_readdatavalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_first: done=%b wait=%b wr=%b addr=%h data=%h rdv=%b expected 0 1 1 0000 0 0",
                     a_init_done, a_m0_waitrequest, a_ram_write, a_ram_address, a_ram_writedata,
                     a_m0_readdatavalid);
        end
        k = 0;
        while (k < 20000 && a_init_done !== 1'b1) begin
            tick();
            sample();
            k++;
        end
        tests_run++;
        if (k != 16384) begin
            tests_failed++;
            $display("FAIL clr_length: cycles=%0d expected 16384", k);
        end
        tests_run++;
        if (a_m0_waitrequest !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_resume: wait=%b expected 0", a_m0_waitrequest);
        end
        tick();
        idle();
        sample();
        tests_run++;
        if (a_m0_readdatavalid !== 1'b1 || a_m0_readdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL clr_readback: rdv=%b data=%h expected 1 0", a_m0_readdatavalid, a_m0_readdata);
        end
    endtask

    task automatic test_clear_on_reset();
        do_reset();
        sample();
        tests_run++;
        if (b_init_done !== 1'b0 || b_ram_chipselect !== 1'b0) begin
            tests_failed++;
            $display("FAIL b_cycle1: done=%b cs=%b expected 0 0", b_init_done, b_ram_chipselect);
        end
        for (int c = 2; c <= 18; c++) begin
            tick();
            sample();
            tests_run++;
            if (c <= 17) begin
                if (b_init_done !== 1'b0 || b_ram_chipselect !== 1'b1 || b_ram_write !== 1'b1 ||
                    b_ram_address !== 4'(c - 2) || b_ram_byteenable !== 4'hF || b_ram_writedata !== 32'h0) begin
                    tests_failed++;
                    $display("FAIL b_clear[%0d]: done=%b cs=%b wr=%b addr=%h be=%h data=%h expected 0 1 1 %h f 0",
                             c, b_init_done, b_ram_chipselect, b_ram_write, b_ram_address,
                             b_ram_byteenable, b_ram_writedata, 4'(c - 2));
                end
            end else if (b_init_done !== 1'b1 || b_ram_chipselect !== 1'b0) begin
                tests_failed++;
                $display("FAIL b_done18: done=%b cs=%b expected 1 0", b_init_done, b_ram_chipselect);
            end
        end
        tick();
        m0_read = 1'b1; m0_address = 14'h0005;
        sample();
        tests_run++;
        if (b_m0_waitrequest !== 1'b0) begin
            tests_failed++;
            $display("FAIL b_read_accept: wait=%b expected 0", b_m0_waitrequest);
        end
        tick();
        m0_address = 14'h000F;
        sample();
        tests_run++;
        if (b_m0_readdatavalid !== 1'b1 || b_m0_readdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL b_zero5: rdv=%b data=%h expected 1 0", b_m0_readdatavalid, b_m0_readdata);
        end
        tick();
        idle();
        sample();
        tests_run++;
        if (b_m0_readdatavalid !== 1'b1 || b_m0_readdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL b_zero15: rdv=%b data=%h expected 1 0", b_m0_readdatavalid, b_m0_readdata);
        end
    endtask

    task automatic test_fixed_priority();
        tick();
        m0_read = 1'b1; m0_address = 14'h0003;
        m1_read = 1'b1; m1_address = 14'h0004;
        for (int i = 0; i < 5; i++) begin
            sample();
            tests_run++;
            if (b_m0_waitrequest !== 1'b0 || b_m1_waitrequest !== 1'b1) begin
                tests_failed++;
                $display("FAIL fp_grant[%0d]: wait=%b%b expected 01", i, b_m0_waitrequest, b_m1_waitrequest);
            end
            if (i > 0) begin
                tests_run++;
                if (b_m0_readdatavalid !== 1'b1 || b_m1_readdatavalid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL fp_valid[%0d]: rdv=%b%b expected 10", i, b_m0_readdatavalid, b_m1_readdatavalid);
                end
            end
            tick();
        end
        idle();
        sample();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_byte_write();
        test_rw_conflict();
        test_clear_req();
        test_clear_on_reset();
        test_fixed_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
